pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Sequencing controller for the five-stage RISC-V pipeline (PC → IF/ID → ID/EX → EX/MEM → MEM/WB). It owns the PC enable, the IF/ID enable and flush, the NOP select of the control-unit mux, and a whole-pipeline hold. It also produces ID-stage operand forwarding selects. It sits in ID beside the control unit and watches the rd/RF_enable/load_instr fields carried in the EX, MEM and WB control words.

## Interface
- BOOT_CYCLES, 4: cycles after reset with the front end held while instruction ROM contents settle; legal range 1..15.
- clk  in  1  pipeline clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- id_rs1, id_rs2  in  5  source registers of the instruction in IF/ID.
- id_uses_rs1, id_uses_rs2  in  1  instruction actually reads the operand.
- ex_rd, mem_rd, wb_rd  in  5  destination register per stage.
- ex_rf_en, mem_rf_en, wb_rf_en  in  1  RF_enable bit of each stage's control word.
- ex_load  in  1  load_instr bit of the EX control word.
- ex_take_branch  in  1  branch or jump resolved taken in EX this cycle.
- ext_stall  in  1  external hold request (data memory busy).
- pc_e  out  1  PC load enable.
- if_id_e  out  1  IF/ID load enable.
- if_id_flush  out  1  IF/ID loads NOP instead of fetched word.
- nop_s  out  1  control-unit mux select; 1 sends all-zero control word to ID/EX.
- pipe_e  out  1  load enable for ID/EX, EX/MEM and MEM/WB.
- fwd_a, fwd_b  out  2  operand source: 00 RF, 01 EX, 10 MEM, 11 WB.
- state  out  2  current FSM state, for debug.

## Operation
- FSM states: BOOT=00, RUN=01, STALL=10, FLUSH=11. Registered state; outputs are combinational from state plus current inputs.
- BOOT: down-counter loaded with BOOT_CYCLES-1 on reset. Outputs are pc_e=0, if_id_e=0, nop_s=1, pipe_e=1, flush=0. Go to RUN when the counter reaches 0.
- Load-use hazard (LU): ex_load & ex_rf_en & ex_rd≠0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- Priority in RUN is ext_stall > ex_take_branch > LU > normal.
  - ext_stall: pc_e=if_id_e=pipe_e=0, nop_s=0; state holds.
  - Branch: pc_e=1, if_id_flush=1, if_id_e=1, nop_s=1; go to FLUSH.
  - LU: pc_e=0, if_id_e=0, nop_s=1; go to STALL.
  - Normal: pc_e=if_id_e=pipe_e=1, nop_s=0, flush=0.
- STALL: LU detection is ignored because the load is now in MEM and is forwarded. A taken branch is still honoured, giving FLUSH. Otherwise the state returns to RUN with normal outputs.
- FLUSH: ex_take_branch is ignored because the EX instruction is a bubble. LU is evaluated as in RUN. Otherwise the state returns to RUN.
- ext_stall in STALL or FLUSH freezes both the state and all enables, exactly as in RUN.
- Forwarding, per operand: a source register of 0 or a non-used operand selects 00. Otherwise EX if ex_rf_en & ~ex_load & ex_rd==rs. Else MEM on a match with mem_rf_en. Else WB on a match with wb_rf_en. Else RF. The nearest stage wins.

## Timing
- Reset values: state=BOOT, boot counter=BOOT_CYCLES-1, pc_e=0, if_id_e=0, if_id_flush=0, nop_s=1, pipe_e=1, fwd=00.
- Reset asserted mid-operation returns to BOOT on the next edge, whatever the current state or ext_stall.
- Hazard response has zero latency: enables change in the same cycle the condition appears.
- The first PC increment occurs on the edge after BOOT_CYCLES reset-released cycles.
- A load-use costs exactly 1 bubble. A taken branch costs exactly 2 squashed instructions: IF/ID is flushed and ID is replaced by NOP.
- Branch and LU in the same cycle: the branch wins and no STALL is entered.

## Configuration
- HAZARD_CTRL_PERF_EN defined: adds outputs stall_cnt[15:0], flush_cnt[15:0] and ext_hold_cnt[15:0].
  - These count cycles in STALL, cycles in FLUSH, and ext_stall cycles respectively.
  - Each saturates at 16'hFFFF and clears on reset.
- HAZARD_CTRL_PERF_EN undefined: these ports and counters are absent, and the block is otherwise identical.

## Structure
- Package hazard_ctrl_pkg holds:
  - the state encodings (BOOT, RUN, STALL, FLUSH);
  - the forwarding encodings (FWD_RF, FWD_EX, FWD_MEM, FWD_WB);
  - the control-word bit positions for RF_enable (15) and load_instr (16).
- Sub-module hazard_fwd_sel holds one operand's forwarding comparator. It is instantiated twice, for fwd_a and fwd_b.

## Test plan
- Reset held 2 cycles with BOOT_CYCLES=4, then released → pc_e=0 for 4 cycles, then pc_e=1 and state=RUN; nop_s=1 throughout BOOT.
- LB x5 in EX, ADDI in ID reading rs1=x5 → that cycle pc_e=0, if_id_e=0, nop_s=1. Next cycle state=STALL, fwd_a=10, pc_e=1. Then RUN.
- SUB in ID with rs2=x7, x7 written by ADDI in EX and by an older ADDI in WB → fwd_b=01. With rs=x0 under the same conditions → fwd_b=00.
- ex_take_branch=1 together with an LU condition → if_id_flush=1, nop_s=1, pc_e=1, next state=FLUSH, no STALL. A spurious ex_take_branch in FLUSH → ignored.
- ext_stall held 3 cycles during STALL → pc_e=if_id_e=pipe_e=0, state stays STALL. After release, RUN follows one cycle later.
- reset asserted while in FLUSH → next edge state=BOOT and all outputs at their reset values. With HAZARD_CTRL_PERF_EN defined, all counters read 0.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'b00,
        ST_RUN   = 2'b01,
        ST_STALL = 2'b10,
        ST_FLUSH = 2'b11
    } hz_state_e;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_EX  = 2'b01,
        FWD_MEM = 2'b10,
        FWD_WB  = 2'b11
    } fwd_e;

    localparam int unsigned CW_RF_EN_BIT = 15;
    localparam int unsigned CW_LOAD_BIT  = 16;

endpackage

// File: rtl/hazard_fwd_sel.sv
// One operand's forwarding comparator; the nearest producing stage wins.
module hazard_fwd_sel
    import hazard_ctrl_pkg::*;
(
    input  logic [4:0] rs_i,
    input  logic       uses_i,
    input  logic [4:0] ex_rd_i,
    input  logic       ex_rf_en_i,
    input  logic       ex_load_i,
    input  logic [4:0] mem_rd_i,
    input  logic       mem_rf_en_i,
    input  logic [4:0] wb_rd_i,
    input  logic       wb_rf_en_i,
    output fwd_e       fwd_o
);

    always_comb begin
        fwd_o = FWD_RF;
        if (uses_i && rs_i != 5'd0) begin
            // A load in EX has no data yet; it is covered by the load-use stall.
            if (ex_rf_en_i && !ex_load_i && ex_rd_i == rs_i) begin
                fwd_o = FWD_EX;
            end else if (mem_rf_en_i && mem_rd_i == rs_i) begin
                fwd_o = FWD_MEM;
            end else if (wb_rf_en_i && wb_rd_i == rs_i) begin
                fwd_o = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Five-stage pipeline sequencing: boot hold, load-use stall, branch flush.
// Define HAZARD_CTRL_PERF_EN to add saturating stall/flush/ext-hold counters.
module pipeline_hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned BOOT_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic [4:0]  ex_rd,
    input  logic [4:0]  mem_rd,
    input  logic [4:0]  wb_rd,
    input  logic        ex_rf_en,
    input  logic        mem_rf_en,
    input  logic        wb_rf_en,
    input  logic        ex_load,
    input  logic        ex_take_branch,
    input  logic        ext_stall,
    output logic        pc_e,
    output logic        if_id_e,
    output logic        if_id_flush,
    output logic        nop_s,
    output logic        pipe_e,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic [1:0]  state
`ifdef HAZARD_CTRL_PERF_EN
    ,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt,
    output logic [15:0] ext_hold_cnt
`endif
);

    localparam logic [3:0] BOOT_INIT = 4'(BOOT_CYCLES - 1);

    hz_state_e  state_q, state_d;
    logic [3:0] boot_q;
    logic       lu_hit;
    fwd_e       fwd_a_w, fwd_b_w;

    assign lu_hit = ex_load && ex_rf_en && ex_rd != 5'd0 &&
                    ((id_uses_rs1 && id_rs1 == ex_rd) ||
                     (id_uses_rs2 && id_rs2 == ex_rd));

    always_comb begin
        state_d     = state_q;
        pc_e        = 1'b1;
        if_id_e     = 1'b1;
        if_id_flush = 1'b0;
        nop_s       = 1'b0;
        pipe_e      = 1'b1;
        if (state_q == ST_BOOT) begin
            pc_e    = 1'b0;
            if_id_e = 1'b0;
            nop_s   = 1'b1;
            if (boot_q == 4'd0) begin
                state_d = ST_RUN;
            end
        end else if (ext_stall) begin
            pc_e    = 1'b0;
            if_id_e = 1'b0;
            pipe_e  = 1'b0;
        end else if (ex_take_branch && state_q != ST_FLUSH) begin
            // In FLUSH the EX slot holds a bubble, so its branch bit is stale.
            if_id_flush = 1'b1;
            nop_s       = 1'b1;
            state_d     = ST_FLUSH;
        end else if (lu_hit && state_q != ST_STALL) begin
            pc_e    = 1'b0;
            if_id_e = 1'b0;
            nop_s   = 1'b1;
            state_d = ST_STALL;
        end else begin
            state_d = ST_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_BOOT;
            boot_q  <= BOOT_INIT;
        end else begin
            state_q <= state_d;
            if (state_q == ST_BOOT && boot_q != 4'd0) begin
                boot_q <= boot_q - 4'd1;
            end
        end
    end

    hazard_fwd_sel u_fwd_a (
        .rs_i        (id_rs1),
        .uses_i      (id_uses_rs1),
        .ex_rd_i     (ex_rd),
        .ex_rf_en_i  (ex_rf_en),
        .ex_load_i   (ex_load),
        .mem_rd_i    (mem_rd),
        .mem_rf_en_i (mem_rf_en),
        .wb_rd_i     (wb_rd),
        .wb_rf_en_i  (wb_rf_en),
        .fwd_o       (fwd_a_w)
    );

    hazard_fwd_sel u_fwd_b (
        .rs_i        (id_rs2),
        .uses_i      (id_uses_rs2),
        .ex_rd_i     (ex_rd),
        .ex_rf_en_i  (ex_rf_en),
        .ex_load_i   (ex_load),
        .mem_rd_i    (mem_rd),
        .mem_rf_en_i (mem_rf_en),
        .wb_rd_i     (wb_rd),
        .wb_rf_en_i  (wb_rf_en),
        .fwd_o       (fwd_b_w)
    );

    // Nothing real issues during BOOT, so selects stay at their reset value.
    assign fwd_a = (state_q == ST_BOOT) ? FWD_RF : fwd_a_w;
    assign fwd_b = (state_q == ST_BOOT) ? FWD_RF : fwd_b_w;
    assign state = state_q;

`ifdef HAZARD_CTRL_PERF_EN
    logic [15:0] stall_cnt_q, flush_cnt_q, ext_hold_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q    <= '0;
            flush_cnt_q    <= '0;
            ext_hold_cnt_q <= '0;
        end else begin
            if (state_q == ST_STALL && stall_cnt_q != 16'hFFFF) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
            if (state_q == ST_FLUSH && flush_cnt_q != 16'hFFFF) begin
                flush_cnt_q <= flush_cnt_q + 16'd1;
            end
            if (ext_stall && ext_hold_cnt_q != 16'hFFFF) begin
                ext_hold_cnt_q <= ext_hold_cnt_q + 16'd1;
            end
        end
    end

    assign stall_cnt    = stall_cnt_q;
    assign flush_cnt    = flush_cnt_q;
    assign ext_hold_cnt = ext_hold_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed literal checks plus random
// stimulus compared every cycle against an event-level reference model.
module tb_pipeline_hazard_ctrl;

    localparam int BOOT = 4;
    localparam int EV_BOOT = 0, EV_HOLD = 1, EV_BR = 2, EV_LU = 3, EV_NORM = 4;

    logic clk = 1'b0;
    logic reset;
    logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;
    logic id_uses_rs1, id_uses_rs2, ex_rf_en, mem_rf_en, wb_rf_en;
    logic ex_load, ex_take_branch, ext_stall;
    logic pc_e, if_id_e, if_id_flush, nop_s, pipe_e;
    logic [1:0] fwd_a, fwd_b, state;
`ifdef HAZARD_CTRL_PERF_EN
    logic [15:0] stall_cnt, flush_cnt, ext_hold_cnt;
    int m_stall, m_flush, m_hold;
`endif

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;
    int m_mode = 0;
    int m_left = BOOT;
    // {pc_e, if_id_e, if_id_flush, nop_s, pipe_e} per event
    logic [4:0] ctl_tbl [5] = '{5'b00011, 5'b00000, 5'b11111, 5'b00011, 5'b11001};

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.BOOT_CYCLES(BOOT)) dut (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .ex_rf_en(ex_rf_en), .mem_rf_en(mem_rf_en), .wb_rf_en(wb_rf_en),
        .ex_load(ex_load), .ex_take_branch(ex_take_branch),
        .ext_stall(ext_stall),
        .pc_e(pc_e), .if_id_e(if_id_e), .if_id_flush(if_id_flush),
        .nop_s(nop_s), .pipe_e(pipe_e),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .state(state)
`ifdef HAZARD_CTRL_PERF_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
        .ext_hold_cnt(ext_hold_cnt)
`endif
    );

    task automatic cmp(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, got, exp);
        end
    endtask

    function automatic bit lu_m();
        logic [4:0] rs [2];
        bit use_ [2];
        rs[0] = id_rs1; rs[1] = id_rs2;
        use_[0] = id_uses_rs1; use_[1] = id_uses_rs2;
        if (!(ex_load && ex_rf_en) || ex_rd == 0) return 1'b0;
        for (int i = 0; i < 2; i++)
            if (use_[i] && rs[i] == ex_rd) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int fwd_m(input logic [4:0] rs, input bit used);
        logic [4:0] rd [3];
        bit ok [3];
        if (m_mode == 0 || !used || rs == 0) return 0;
        rd[0] = ex_rd;  ok[0] = ex_rf_en && !ex_load;
        rd[1] = mem_rd; ok[1] = mem_rf_en;
        rd[2] = wb_rd;  ok[2] = wb_rf_en;
        for (int i = 0; i < 3; i++)
            if (ok[i] && rd[i] == rs) return i + 1;
        return 0;
    endfunction

    function automatic int ev_of();
        if (m_mode == 0) return EV_BOOT;
        if (ext_stall) return EV_HOLD;
        if (ex_take_branch && m_mode != 3) return EV_BR;
        if (lu_m() && m_mode != 2) return EV_LU;
        return EV_NORM;
    endfunction

    function automatic int mode_after(input int ev);
        case (ev)
            EV_BOOT: return (m_left == 1) ? 1 : 0;
            EV_HOLD: return m_mode;
            EV_BR:   return 3;
            EV_LU:   return 2;
            default: return 1;
        endcase
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_mode <= 0;
            m_left <= BOOT;
        end else begin
            m_mode <= mode_after(ev_of());
            if (m_mode == 0) m_left <= m_left - 1;
        end
`ifdef HAZARD_CTRL_PERF_EN
        if (reset) begin
            m_stall <= 0; m_flush <= 0; m_hold <= 0;
        end else begin
            if (m_mode == 2 && m_stall < 65535) m_stall <= m_stall + 1;
            if (m_mode == 3 && m_flush < 65535) m_flush <= m_flush + 1;
            if (ext_stall && m_hold < 65535) m_hold <= m_hold + 1;
        end
`endif
    end

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("ctl", {pc_e, if_id_e, if_id_flush, nop_s, pipe_e}, ctl_tbl[ev_of()]);
            cmp("state", state, m_mode);
            cmp("fwd_a", fwd_a, fwd_m(id_rs1, id_uses_rs1));
            cmp("fwd_b", fwd_b, fwd_m(id_rs2, id_uses_rs2));
`ifdef HAZARD_CTRL_PERF_EN
            cmp("stall_cnt", stall_cnt, m_stall);
            cmp("flush_cnt", flush_cnt, m_flush);
            cmp("ext_hold_cnt", ext_hold_cnt, m_hold);
`endif
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
        ex_rd = 0; mem_rd = 0; wb_rd = 0;
        ex_rf_en = 0; mem_rf_en = 0; wb_rf_en = 0;
        ex_load = 0; ex_take_branch = 0; ext_stall = 0;
    endtask

    task automatic set_lu();
        ex_load = 1; ex_rf_en = 1; ex_rd = 5;
        id_rs1 = 5; id_uses_rs1 = 1;
    endtask

    initial begin
        reset = 1'b1;
        clr();
        cyc();
        chk_en = 1'b1;
        cmp("rst_state", state, 0);
        cmp("rst_pc_e", pc_e, 0);
        cmp("rst_nop_s", nop_s, 1);
        cyc();
        reset = 1'b0;
        for (int i = 0; i < BOOT; i++) begin
            #1;
            cmp("boot_pc_e", pc_e, 0);
            cmp("boot_nop_s", nop_s, 1);
            cyc();
        end
        #1;
        cmp("run_pc_e", pc_e, 1);
        cmp("run_state", state, 1);

        set_lu();
        #1;
        cmp("lu_pc_e", pc_e, 0);
        cmp("lu_if_id_e", if_id_e, 0);
        cmp("lu_nop_s", nop_s, 1);
        cyc();
        clr();
        id_rs1 = 5; id_uses_rs1 = 1; mem_rd = 5; mem_rf_en = 1;
        #1;
        cmp("stall_state", state, 2);
        cmp("stall_fwd_a", fwd_a, 2);
        cmp("stall_pc_e", pc_e, 1);
        cyc();
        clr();
        #1;
        cmp("after_stall_state", state, 1);

        id_rs2 = 7; id_uses_rs2 = 1; ex_rd = 7; ex_rf_en = 1;
        wb_rd = 7; wb_rf_en = 1;
        #1;
        cmp("fwd_b_ex", fwd_b, 1);
        id_rs2 = 0;
        #1;
        cmp("fwd_b_x0", fwd_b, 0);

        cyc();
        clr();
        set_lu();
        ex_take_branch = 1;
        #1;
        cmp("br_flush", if_id_flush, 1);
        cmp("br_nop_s", nop_s, 1);
        cmp("br_pc_e", pc_e, 1);
        cyc();
        clr();
        ex_take_branch = 1;
        #1;
        cmp("flush_state", state, 3);
        cmp("flush_spurious_br", if_id_flush, 0);
        cyc();
        clr();
        #1;
        cmp("after_flush_state", state, 1);

        set_lu();
        cyc();
        clr();
        ext_stall = 1;
        #1;
        cmp("hold_pc_e", pc_e, 0);
        cmp("hold_if_id_e", if_id_e, 0);
        cmp("hold_pipe_e", pipe_e, 0);
        for (int i = 0; i < 2; i++) begin
            cyc();
            #1;
            cmp("hold_state", state, 2);
        end
        cyc();
        ext_stall = 0;
        #1;
        cmp("hold_rel_state", state, 2);
        cmp("hold_rel_pc_e", pc_e, 1);
        cyc();
        #1;
        cmp("hold_done_state", state, 1);

        ex_take_branch = 1;
        cyc();
        clr();
        #1;
        cmp("pre_rst_state", state, 3);
        reset = 1; ext_stall = 1;
        id_rs1 = 5; id_uses_rs1 = 1; mem_rd = 5; mem_rf_en = 1;
        cyc();
        #1;
        cmp("mid_rst_state", state, 0);
        cmp("mid_rst_ctl", {pc_e, if_id_e, if_id_flush, nop_s, pipe_e}, 5'b00011);
        cmp("mid_rst_fwd_a", fwd_a, 0);
`ifdef HAZARD_CTRL_PERF_EN
        cmp("mid_rst_cnts", stall_cnt | flush_cnt | ext_hold_cnt, 0);
`endif
        reset = 0;
        clr();

        for (int n = 0; n < 3000; n++) begin
            cyc();
            reset = ($urandom_range(0, 299) == 0);
            id_rs1 = 5'($urandom_range(0, 7));
            id_rs2 = 5'($urandom_range(0, 7));
            id_uses_rs1 = 1'($urandom_range(0, 3) != 0);
            id_uses_rs2 = 1'($urandom_range(0, 1));
            ex_rd = 5'($urandom_range(0, 7));
            mem_rd = 5'($urandom_range(0, 7));
            wb_rd = 5'($urandom_range(0, 7));
            ex_rf_en = 1'($urandom_range(0, 3) != 0);
            mem_rf_en = 1'($urandom_range(0, 1));
            wb_rf_en = 1'($urandom_range(0, 1));
            ex_load = 1'($urandom_range(0, 2) == 0);
            ex_take_branch = 1'($urandom_range(0, 5) == 0);
            ext_stall = 1'($urandom_range(0, 7) == 0);
        end
        cyc();
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
